// File: rtl/ysyx_25040105_pkg.sv
// Shared definitions for the NPC multi-cycle sequencer: state encoding,
// halt codes and the default reset PC.
package ysyx_25040105_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_FETCH_REQ  = 4'd1;
  localparam logic [3:0] ST_FETCH_WAIT = 4'd2;
  localparam logic [3:0] ST_DECODE     = 4'd3;
  localparam logic [3:0] ST_EXEC       = 4'd4;
  localparam logic [3:0] ST_MEM_REQ    = 4'd5;
  localparam logic [3:0] ST_MEM_WAIT   = 4'd6;
  localparam logic [3:0] ST_WB         = 4'd7;
  localparam logic [3:0] ST_HALT       = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE       = ST_IDLE,
    S_FETCH_REQ  = ST_FETCH_REQ,
    S_FETCH_WAIT = ST_FETCH_WAIT,
    S_DECODE     = ST_DECODE,
    S_EXEC       = ST_EXEC,
    S_MEM_REQ    = ST_MEM_REQ,
    S_MEM_WAIT   = ST_MEM_WAIT,
    S_WB         = ST_WB,
    S_HALT       = ST_HALT
  } state_e;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_EBREAK  = 2'b01;
  localparam logic [1:0] HALT_ILLEGAL = 2'b10;
  localparam logic [1:0] HALT_TIMEOUT = 2'b11;

endpackage

// File: rtl/ysyx_25040105_wait_timer.sv
// Wait-state watchdog shared by FETCH_WAIT and MEM_WAIT; expired_o flags
// the last permitted cycle without a response.
module ysyx_25040105_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_25040105_core_seq.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the NPC
// core; owns PC, instruction latch, rf write strobe, halt status and counters.
module ysyx_25040105_core_seq
  import ysyx_25040105_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_ebreak,
  input  logic        dec_illegal,
  input  logic        dec_reg_wen,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  output logic        rf_wen,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic [1:0]  halt_code_q, halt_code_d;
  logic        ld_q, ld_d, st_q, st_d, wen_q, wen_d;
  logic [63:0] cycle_q, instret_q;
  logic        retire;
  logic        waiting, wait_rsp, tmr_expired;

  assign waiting  = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_WAIT);
  assign wait_rsp = (state_q == S_FETCH_WAIT) ? imem_rsp_valid : dmem_rsp_valid;

  ysyx_25040105_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!waiting),
    .en_i      (waiting && !wait_rsp),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    halt_code_d = halt_code_q;
    ld_d        = ld_q;
    st_d        = st_q;
    wen_d       = wen_q;
    retire      = 1'b0;
    case (state_q)
      S_IDLE:      state_d = S_FETCH_REQ;
      S_FETCH_REQ: if (imem_req_ready) state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_TIMEOUT;
        end
      end
      S_DECODE: begin
        ld_d  = dec_is_load;
        st_d  = dec_is_store;
        wen_d = dec_reg_wen;
        if (dec_illegal || (dec_is_load && dec_is_store)) begin
          state_d     = S_HALT;
          halt_code_d = HALT_ILLEGAL;
        end else if (dec_is_ebreak) begin
          state_d     = S_HALT;
          halt_code_d = HALT_EBREAK;
          retire      = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:    state_d = (ld_q || st_q) ? S_MEM_REQ : S_WB;
      S_MEM_REQ: if (dmem_req_ready) state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d = S_WB;
        end else if (tmr_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_TIMEOUT;
        end
      end
      S_WB: begin
        pc_d    = next_pc;
        retire  = 1'b1;
        state_d = S_FETCH_REQ;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      halt_code_q <= HALT_NONE;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      wen_q       <= 1'b0;
      cycle_q     <= 64'd0;
      instret_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      halt_code_q <= halt_code_d;
      ld_q        <= ld_d;
      st_q        <= st_d;
      wen_q       <= wen_d;
      if (state_q != S_HALT) cycle_q <= cycle_q + 64'd1;
      if (retire) instret_q <= instret_q + 64'd1;
    end
  end

  // All outputs are pure state decodes; no ready/valid input reaches them.
  assign imem_req_valid = (state_q == S_FETCH_REQ);
  assign imem_addr      = pc_q;
  assign dmem_req_valid = (state_q == S_MEM_REQ);
  assign rf_wen         = (state_q == S_WB) && wen_q && !st_q;
  assign halt           = (state_q == S_HALT);
  assign halt_code      = halt_code_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign cycle_cnt      = cycle_q;
  assign instret        = instret_q;

endmodule

// File: doc/ysyx_25040105_core_seq.md
Name: ysyx_25040105_core_seq

Overview:
Multi-cycle sequencer for the NPC core. Drives the fetch, decode, execute, memory and writeback phases around the existing decode and execute datapath. Owns the PC register, the latched instruction register and the register-file write strobe, and handshakes with the instruction and data memory ports. Provides halt status (ebreak, illegal instruction, memory timeout) and cycle/instret performance counters for the simulation harness.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 16, cycles allowed in a wait state before a timeout halt; legal range 2..255.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  fetch request accepted
imem_addr  output  32  fetch address; always equals pc
imem_rsp_valid  input  1  fetch data valid
imem_rdata  input  32  fetched instruction
inst  output  32  latched instruction, feeds the IDU
pc  output  32  current PC
next_pc  input  32  PC computed by the EXU, valid in EXEC and WB
dec_is_load  input  1  IDU: load instruction
dec_is_store  input  1  IDU: store instruction
dec_is_ebreak  input  1  IDU: ebreak
dec_illegal  input  1  IDU: unrecognised encoding
dec_reg_wen  input  1  IDU: instruction writes rd
dmem_req_valid  output  1  data request valid
dmem_req_ready  input  1  data request accepted
dmem_rsp_valid  input  1  data response (load data or store ack)
rf_wen  output  1  register-file write strobe, one cycle
halt  output  1  sticky halt flag
halt_code  output  2  00 none, 01 ebreak, 10 illegal, 11 timeout
cycle_cnt  output  64  cycles since reset, excluding HALT
instret  output  64  retired instructions

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pc=RESET_PC, inst=0, counters=0, halt=0, halt_code=00. All valid and strobe outputs are 0.
- All control outputs are Moore outputs decoded from state. There are no combinational paths from the ready/valid inputs to outputs.
- States: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- IDLE: 1 cycle after reset release, then goes to FETCH_REQ.
- FETCH_REQ: imem_req_valid=1.
  - Valid is held until imem_req_ready, with imem_addr stable.
  - On ready, go to FETCH_WAIT.
  - imem_rsp_valid is ignored in this state.
- FETCH_WAIT: on imem_rsp_valid, inst<=imem_rdata and go to DECODE.
- DECODE: 1 cycle; dec_* are sampled only here. Priority order:
  - dec_illegal, or both load and store set: HALT, code 10.
  - dec_is_ebreak: HALT, code 01; instret increments.
  - otherwise: EXEC.
- EXEC: 1 cycle. If load or store (flags registered in DECODE), go to MEM_REQ; else WB.
- MEM_REQ: dmem_req_valid=1, held until dmem_req_ready, then MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid, go to WB.
- WB: 1 cycle.
  - rf_wen = registered dec_reg_wen, forced to 0 for stores.
  - pc<=next_pc; instret increments.
  - Next state is FETCH_REQ.
- Timeout:
  - An 8-bit wait counter clears on entry to FETCH_WAIT or MEM_WAIT and increments each cycle without a response.
  - When the counter reaches TIMEOUT-1 with no response, go to HALT, code 11.
  - A response arriving in the same cycle wins over the timeout.
- HALT: terminal until reset. halt=1, halt_code is held, cycle_cnt is frozen, and all requests are 0.
- cycle_cnt increments every cycle in any state except HALT, including IDLE. Both counters wrap modulo 2^64.
- Latency with zero-wait memory (ready immediate, response one cycle after acceptance):
  - ALU instruction: 5 cycles FETCH_REQ to FETCH_REQ.
  - Load/store: 7 cycles.
- PC wrap: next_pc is taken as-is; no alignment check here.
- Reset mid-transaction: asynchronously aborts everything. Outstanding memory responses after reset are not tracked and are ignored unless in a wait state.

Decomposition:
- Shared package (ysyx_25040105_pkg) holds:
  - state encoding as localparams,
  - HALT_NONE/EBREAK/ILLEGAL/TIMEOUT codes,
  - the RESET_PC default.
- Sub-module: ysyx_25040105_wait_timer — 8-bit counter with clear/enable inputs and an expired output, instantiated once and shared by both wait states.

Test Plan:
- ALU stream: addi at 0x8000_0000, next_pc = pc+4, zero-wait memory.
  - Required: imem_req_valid asserted every 5 cycles.
  - Required: rf_wen one cycle per instruction.
  - Required: pc=0x8000_000C after 3 retirements, instret=3.
- Back-pressure: imem_req_ready low for 4 cycles.
  - Required: valid held high and imem_addr stable for all 4 cycles.
  - Required: exactly one fetch accepted, instret=1 after WB.
- Load with dmem_rsp_valid delayed 3 cycles.
  - Required: 10 cycles fetch-to-fetch.
  - Required: rf_wen=1 in WB.
  - Required: a store variant gives rf_wen=0.
- Ebreak as the 2nd instruction.
  - Required: halt=1, halt_code=01, instret=2.
  - Required: cycle_cnt frozen, and no further imem_req_valid for 20 cycles.
- Fetch timeout with TIMEOUT=16 and imem_rsp_valid never asserted.
  - Required: HALT code 11 exactly 16 cycles after entering FETCH_WAIT.
  - Required: a response in cycle 16 instead goes to DECODE.
- Async reset asserted in MEM_WAIT.
  - Required: outputs 0 immediately (no clock edge needed), pc=RESET_PC.
  - Required: after release, IDLE for 1 cycle, then imem_req_valid=1.
  - Also: dec_illegal=1 together with dec_is_ebreak=1 gives halt_code=10.
